// File: rtl/ctrl_mc.sv
// ctrl_mc: multi-cycle rysyCore control unit with combinational decode and an EXEC/MEM_WAIT/WB/FLUSH sequencer.
// Define CTRL_MC_TIMEOUT_EN to bound MEM_WAIT by TIMEOUT cycles and raise a sticky err flag on expiry.
module ctrl_mc #(
    parameter int NOP_SLOTS = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] opcode_i,
    input  logic [2:0] func3_i,
    input  logic [6:0] func7_i,
    input  logic       b_i,
    input  logic       dmem_ack_i,
    output logic [2:0] imm_type_o,
    output logic [3:0] alu_op_o,
    output logic [2:0] cmp_op_o,
    output logic       alu1_sel_o,
    output logic       alu2_sel_o,
    output logic [1:0] rd_sel_o,
    output logic [2:0] sel_type_o,
    output logic       reg_wr_o,
    output logic       we_o,
    output logic       mem_sel_o,
    output logic       dmem_req_o,
    output logic [1:0] pc_sel_o,
    output logic [1:0] inst_sel_o,
    output logic       stall_o,
    output logic       illegal_o,
    output logic       err_o
);
    // state    | meaning
    // EXEC     | decode and execute the presented instruction
    // MEM_WAIT | data access outstanding, waiting for dmem_ack
    // WB       | load data written back to the register file
    // FLUSH    | NOPs injected after a taken control transfer
    typedef enum logic [1:0] {EXEC, MEM_WAIT, WB, FLUSH} state_t;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [1:0] PC_TARGET = 2'b00, PC_NEXT = 2'b01, PC_HOLD = 2'b10;
    localparam logic [1:0] INST_FETCH = 2'b00, INST_NOP = 2'b01, INST_HOLD = 2'b10;
    localparam logic [2:0] FLUSH_LOAD = (NOP_SLOTS > 0) ? 3'(NOP_SLOTS - 1) : 3'd0;

    state_t     state_q, state_d;
    logic       rst_q;
    logic       is_store_q, is_store_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic       blk;
    logic       timeout;

    // Sequencing stays parked for the reset cycle and the one after it.
    assign blk = rst_i | rst_q;

    always_comb begin
        imm_type_o = 3'b000;
        alu_op_o   = 4'b0000;
        cmp_op_o   = 3'b000;
        alu1_sel_o = 1'b0;
        alu2_sel_o = 1'b1;
        rd_sel_o   = 2'b10;
        sel_type_o = 3'b000;
        case (opcode_i)
            OPC_OP, OPC_OP_IMM: begin
                if (opcode_i == OPC_OP) alu2_sel_o = 1'b0;
                else                    imm_type_o = 3'b100;
                case (func3_i)
                    3'b000: alu_op_o = (opcode_i == OPC_OP && func7_i == 7'b0100000) ? 4'b0001 : 4'b0000;
                    3'b001: alu_op_o = 4'b0101;
                    3'b010: alu_op_o = 4'b1000;
                    3'b011: alu_op_o = 4'b1001;
                    3'b100: alu_op_o = 4'b0010;
                    3'b101: alu_op_o = (func7_i == 7'b0100000) ? 4'b0111 : 4'b0110;
                    3'b110: alu_op_o = 4'b0011;
                    default: alu_op_o = 4'b0100;
                endcase
            end
            OPC_LUI: begin
                imm_type_o = 3'b001;
                rd_sel_o   = 2'b00;
            end
            OPC_AUIPC: begin
                imm_type_o = 3'b001;
                alu1_sel_o = 1'b1;
            end
            OPC_JAL: begin
                imm_type_o = 3'b101;
                alu1_sel_o = 1'b1;
                rd_sel_o   = 2'b01;
            end
            OPC_JALR: begin
                imm_type_o = 3'b100;
                rd_sel_o   = 2'b01;
            end
            OPC_BRANCH: begin
                imm_type_o = 3'b010;
                alu1_sel_o = 1'b1;
                cmp_op_o   = func3_i;
            end
            OPC_LOAD: begin
                imm_type_o = 3'b100;
                rd_sel_o   = 2'b11;
                sel_type_o = func3_i;
            end
            OPC_STORE: begin
                imm_type_o = 3'b011;
                sel_type_o = func3_i;
            end
            default: ;
        endcase
        // The fetch stage has already moved on during WB, so the memory path is forced.
        if (state_q == WB) rd_sel_o = 2'b11;
    end

`ifdef CTRL_MC_TIMEOUT_EN
    logic [7:0] wait_cnt_q;
    logic       err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != MEM_WAIT) wait_cnt_q <= '0;
        else                              wait_cnt_q <= wait_cnt_q + 8'd1;
    end

    assign timeout = (state_q == MEM_WAIT) && !dmem_ack_i && (wait_cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i)        err_q <= 1'b0;
        else if (timeout) err_q <= 1'b1;
    end

    assign err_o = err_q & ~rst_i;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= EXEC;
            rst_q       <= 1'b1;
            is_store_q  <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rst_q       <= 1'b0;
            is_store_q  <= is_store_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        flush_cnt_d = flush_cnt_q;
        if (rst_q) begin
            state_d     = EXEC;
            flush_cnt_d = '0;
        end else begin
            case (state_q)
                EXEC: begin
                    case (opcode_i)
                        OPC_JAL, OPC_JALR: begin
                            if (NOP_SLOTS > 0) begin
                                state_d     = FLUSH;
                                flush_cnt_d = FLUSH_LOAD;
                            end
                        end
                        OPC_BRANCH: begin
                            if (b_i && NOP_SLOTS > 0) begin
                                state_d     = FLUSH;
                                flush_cnt_d = FLUSH_LOAD;
                            end
                        end
                        OPC_LOAD, OPC_STORE: begin
                            is_store_d = (opcode_i == OPC_STORE);
                            if (!dmem_ack_i)                state_d = MEM_WAIT;
                            else if (opcode_i == OPC_LOAD) state_d = WB;
                        end
                        default: ;
                    endcase
                end
                MEM_WAIT: begin
                    if (dmem_ack_i)   state_d = is_store_q ? EXEC : WB;
                    else if (timeout) state_d = EXEC;
                end
                WB: state_d = EXEC;
                FLUSH: begin
                    if (flush_cnt_q == 3'd0) state_d = EXEC;
                    else                     flush_cnt_d = flush_cnt_q - 3'd1;
                end
            endcase
        end
    end

    always_comb begin
        reg_wr_o   = 1'b0;
        we_o       = 1'b0;
        mem_sel_o  = 1'b0;
        dmem_req_o = 1'b0;
        pc_sel_o   = PC_NEXT;
        inst_sel_o = INST_FETCH;
        illegal_o  = 1'b0;
        if (blk) begin
            pc_sel_o   = PC_HOLD;
            inst_sel_o = INST_NOP;
        end else begin
            case (state_q)
                EXEC: begin
                    case (opcode_i)
                        OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: reg_wr_o = 1'b1;
                        OPC_JAL, OPC_JALR: begin
                            reg_wr_o = 1'b1;
                            pc_sel_o = PC_TARGET;
                        end
                        OPC_BRANCH: if (b_i) pc_sel_o = PC_TARGET;
                        OPC_LOAD, OPC_STORE: begin
                            dmem_req_o = 1'b1;
                            mem_sel_o  = 1'b1;
                            we_o       = (opcode_i == OPC_STORE);
                            if (!(dmem_ack_i && opcode_i == OPC_STORE)) begin
                                pc_sel_o   = PC_HOLD;
                                inst_sel_o = INST_HOLD;
                            end
                        end
                        default: illegal_o = 1'b1;
                    endcase
                end
                MEM_WAIT: begin
                    dmem_req_o = 1'b1;
                    mem_sel_o  = 1'b1;
                    we_o       = is_store_q;
                    if (!(dmem_ack_i && is_store_q) && !timeout) begin
                        pc_sel_o   = PC_HOLD;
                        inst_sel_o = INST_HOLD;
                    end
                end
                WB:    reg_wr_o   = 1'b1;
                FLUSH: inst_sel_o = INST_NOP;
            endcase
        end
    end

    assign stall_o = (pc_sel_o == PC_HOLD);

endmodule

// File: tb/tb_ctrl_mc.sv
// Scoreboard bench for ctrl_mc: index 0 runs NOP_SLOTS=2, index 1 runs NOP_SLOTS=0, both with TIMEOUT=4.
module tb_ctrl_mc;
    localparam logic [4:0] LOAD = 5'b00000, OPI = 5'b00100, AUIPC = 5'b00101, STORE = 5'b01000;
    localparam logic [4:0] OP = 5'b01100, LUI = 5'b01101, BR = 5'b11000, JALR = 5'b11001, JAL = 5'b11011;
    localparam logic [4:0] BAD = 5'b11100;

    // {reg_wr, we, mem_sel, dmem_req, pc_sel, inst_sel, stall, illegal, err}
    localparam logic [10:0] S_RST   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0};
    localparam logic [10:0] S_RUN   = {1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] S_JUMP  = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] S_BR_T  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] S_BR_N  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] S_LD_W  = {1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0};
    localparam logic [10:0] S_ST_W  = {1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0};
    localparam logic [10:0] S_ST_OK = {1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] S_FLUSH = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] S_ILL   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0};
    localparam logic [10:0] S_TO    = {1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0, rst = 1'b1, b = 1'b0, ack = 1'b0;
    logic [4:0] opcode = OP;
    logic [2:0] func3 = 3'b000;
    logic [6:0] func7 = 7'b0000000;

    logic [2:0] imm_type [2];
    logic [3:0] alu_op   [2];
    logic [2:0] cmp_op   [2];
    logic       alu1_sel [2];
    logic       alu2_sel [2];
    logic [1:0] rd_sel   [2];
    logic [2:0] sel_type [2];
    logic       reg_wr [2], we [2], mem_sel [2], dmem_req [2], stall [2], illegal [2], err [2];
    logic [1:0] pc_sel [2], inst_sel [2];

    ctrl_mc #(.NOP_SLOTS(2), .TIMEOUT(4)) u_n2 (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .func3_i(func3), .func7_i(func7), .b_i(b),
        .dmem_ack_i(ack), .imm_type_o(imm_type[0]), .alu_op_o(alu_op[0]), .cmp_op_o(cmp_op[0]),
        .alu1_sel_o(alu1_sel[0]), .alu2_sel_o(alu2_sel[0]), .rd_sel_o(rd_sel[0]),
        .sel_type_o(sel_type[0]), .reg_wr_o(reg_wr[0]), .we_o(we[0]), .mem_sel_o(mem_sel[0]),
        .dmem_req_o(dmem_req[0]), .pc_sel_o(pc_sel[0]), .inst_sel_o(inst_sel[0]), .stall_o(stall[0]),
        .illegal_o(illegal[0]), .err_o(err[0]));

    ctrl_mc #(.NOP_SLOTS(0), .TIMEOUT(4)) u_n0 (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .func3_i(func3), .func7_i(func7), .b_i(b),
        .dmem_ack_i(ack), .imm_type_o(imm_type[1]), .alu_op_o(alu_op[1]), .cmp_op_o(cmp_op[1]),
        .alu1_sel_o(alu1_sel[1]), .alu2_sel_o(alu2_sel[1]), .rd_sel_o(rd_sel[1]),
        .sel_type_o(sel_type[1]), .reg_wr_o(reg_wr[1]), .we_o(we[1]), .mem_sel_o(mem_sel[1]),
        .dmem_req_o(dmem_req[1]), .pc_sel_o(pc_sel[1]), .inst_sel_o(inst_sel[1]), .stall_o(stall[1]),
        .illegal_o(illegal[1]), .err_o(err[1]));

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          which;
        logic [10:0] seq;
        bit          dchk;
        logic [16:0] dec;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // {imm_type, alu_op, cmp_op, alu1_sel, alu2_sel, rd_sel, sel_type}
    function automatic logic [16:0] D(input logic [2:0] imm, input logic [3:0] aop, input logic [2:0] cmp,
                                      input logic a1, input logic a2, input logic [1:0] rd, input logic [2:0] st);
        return {imm, aop, cmp, a1, a2, rd, st};
    endfunction

    task automatic step(input string tag, input int which, input logic r, input logic [4:0] op,
                        input logic [2:0] f3, input logic [6:0] f7, input logic bb, input logic ak,
                        input logic [10:0] es, input bit dc, input logic [16:0] ed);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; opcode = op; func3 = f3; func7 = f7; b = bb; ack = ak;
        e.tag = tag; e.which = which; e.seq = es; e.dchk = dc; e.dec = ed;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        logic [10:0] aseq;
        logic [16:0] adec;
        int w;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                w = e.which;
                aseq = {reg_wr[w], we[w], mem_sel[w], dmem_req[w], pc_sel[w], inst_sel[w],
                        stall[w], illegal[w], err[w]};
                n_cmp++;
                if (aseq !== e.seq) begin
                    n_bad++;
                    $display("FAIL %s seq: got %b want %b", e.tag, aseq, e.seq);
                end
                if (e.dchk) begin
                    adec = {imm_type[w], alu_op[w], cmp_op[w], alu1_sel[w], alu2_sel[w], rd_sel[w], sel_type[w]};
                    n_cmp++;
                    if (adec !== e.dec) begin
                        n_bad++;
                        $display("FAIL %s dec: got %b want %b", e.tag, adec, e.dec);
                    end
                end
            end
        end
    end

    initial begin
        step("rst_hold",  0, 1, OP, 3'b000, 7'h00, 0, 0, S_RST, 0, '0);
        step("rst_after", 0, 0, OP, 3'b000, 7'h00, 0, 0, S_RST, 0, '0);
        step("op_sub",  0, 0, OP, 3'b000, 7'b0100000, 0, 0, S_RUN, 1, D(3'b000, 4'b0001, 3'b000, 0, 0, 2'b10, 3'b000));
        step("op_add",  0, 0, OP, 3'b000, 7'b0000000, 0, 0, S_RUN, 1, D(3'b000, 4'b0000, 3'b000, 0, 0, 2'b10, 3'b000));
        step("op_sra",  0, 0, OP, 3'b101, 7'b0100000, 0, 0, S_RUN, 1, D(3'b000, 4'b0111, 3'b000, 0, 0, 2'b10, 3'b000));
        step("op_srl",  0, 0, OP, 3'b101, 7'b0000000, 0, 0, S_RUN, 1, D(3'b000, 4'b0110, 3'b000, 0, 0, 2'b10, 3'b000));
        step("op_sltu", 0, 0, OP, 3'b011, 7'b0000000, 0, 0, S_RUN, 1, D(3'b000, 4'b1001, 3'b000, 0, 0, 2'b10, 3'b000));
        step("opi_add", 0, 0, OPI, 3'b000, 7'b0100000, 0, 0, S_RUN, 1, D(3'b100, 4'b0000, 3'b000, 0, 1, 2'b10, 3'b000));
        step("opi_sra", 0, 0, OPI, 3'b101, 7'b0100000, 0, 0, S_RUN, 1, D(3'b100, 4'b0111, 3'b000, 0, 1, 2'b10, 3'b000));
        step("lui",     0, 0, LUI, 3'b000, 7'h00, 0, 0, S_RUN, 1, D(3'b001, 4'b0000, 3'b000, 0, 1, 2'b00, 3'b000));
        step("auipc",   0, 0, AUIPC, 3'b000, 7'h00, 0, 0, S_RUN, 1, D(3'b001, 4'b0000, 3'b000, 1, 1, 2'b10, 3'b000));
        step("illegal", 0, 0, BAD, 3'b000, 7'h00, 0, 0, S_ILL, 0, '0);
        step("post_ill", 0, 0, OP, 3'b000, 7'h00, 0, 0, S_RUN, 0, '0);

        step("ld_req",   0, 0, LOAD, 3'b010, 7'h00, 0, 0, S_LD_W, 1, D(3'b100, 4'b0000, 3'b000, 0, 1, 2'b11, 3'b010));
        step("ld_wait1", 0, 0, LOAD, 3'b010, 7'h00, 0, 0, S_LD_W, 0, '0);
        step("ld_wait2", 0, 0, LOAD, 3'b010, 7'h00, 0, 0, S_LD_W, 0, '0);
        step("ld_ack",   0, 0, LOAD, 3'b010, 7'h00, 0, 1, S_LD_W, 0, '0);
        step("ld_wb",    0, 0, OP, 3'b000, 7'h00, 0, 0, S_RUN, 1, D(3'b000, 4'b0000, 3'b000, 0, 0, 2'b11, 3'b000));
        step("stray_ack", 0, 0, OP, 3'b000, 7'h00, 0, 1, S_RUN, 1, D(3'b000, 4'b0000, 3'b000, 0, 0, 2'b10, 3'b000));

        step("st_zero", 0, 0, STORE, 3'b001, 7'h00, 0, 1, S_ST_OK, 1, D(3'b011, 4'b0000, 3'b000, 0, 1, 2'b10, 3'b001));
        step("st_next", 0, 0, OP, 3'b000, 7'h00, 0, 0, S_RUN, 0, '0);
        step("st_req",  0, 0, STORE, 3'b010, 7'h00, 0, 0, S_ST_W, 0, '0);
        step("st_wait", 0, 0, STORE, 3'b010, 7'h00, 0, 0, S_ST_W, 0, '0);
        step("st_ack",  0, 0, STORE, 3'b010, 7'h00, 0, 1, S_ST_OK, 0, '0);
        step("st_done", 0, 0, OP, 3'b000, 7'h00, 0, 0, S_RUN, 0, '0);

        step("br_taken", 0, 0, BR, 3'b101, 7'h00, 1, 0, S_BR_T, 1, D(3'b010, 4'b0000, 3'b101, 1, 1, 2'b10, 3'b000));
        step("br_nop1",  0, 0, OP, 3'b000, 7'h00, 0, 0, S_FLUSH, 0, '0);
        step("br_nop2",  0, 0, OP, 3'b000, 7'h00, 0, 0, S_FLUSH, 0, '0);
        step("br_resume", 0, 0, OP, 3'b000, 7'h00, 0, 0, S_RUN, 0, '0);
        step("br_not",   0, 0, BR, 3'b000, 7'h00, 0, 0, S_BR_N, 0, '0);
        step("br_not_nx", 0, 0, OP, 3'b000, 7'h00, 0, 0, S_RUN, 0, '0);
        step("jal",      0, 0, JAL, 3'b000, 7'h00, 0, 0, S_JUMP, 1, D(3'b101, 4'b0000, 3'b000, 1, 1, 2'b01, 3'b000));
        step("jal_nop1", 0, 0, OP, 3'b000, 7'h00, 0, 0, S_FLUSH, 0, '0);
        step("jal_nop2", 0, 0, OP, 3'b000, 7'h00, 0, 0, S_FLUSH, 0, '0);
        step("jal_resume", 0, 0, OP, 3'b000, 7'h00, 0, 0, S_RUN, 0, '0);

        step("n0_rst",    1, 1, OP, 3'b000, 7'h00, 0, 0, S_RST, 0, '0);
        step("n0_rst_nx", 1, 0, OP, 3'b000, 7'h00, 0, 0, S_RST, 0, '0);
        step("n0_br",     1, 0, BR, 3'b000, 7'h00, 1, 0, S_BR_T, 0, '0);
        step("n0_br_nx",  1, 0, OP, 3'b000, 7'h00, 0, 0, S_RUN, 0, '0);
        step("n0_jalr",   1, 0, JALR, 3'b000, 7'h00, 0, 0, S_JUMP, 0, '0);
        step("n0_jalr_nx", 1, 0, OP, 3'b000, 7'h00, 0, 0, S_RUN, 0, '0);

        step("mw_rst0",   0, 1, OP, 3'b000, 7'h00, 0, 0, S_RST, 0, '0);
        step("mw_rst1",   0, 0, OP, 3'b000, 7'h00, 0, 0, S_RST, 0, '0);
        step("mw_req",    0, 0, LOAD, 3'b000, 7'h00, 0, 0, S_LD_W, 0, '0);
        step("mw_wait",   0, 0, LOAD, 3'b000, 7'h00, 0, 0, S_LD_W, 0, '0);
        step("mw_rst",    0, 1, LOAD, 3'b000, 7'h00, 0, 0, S_RST, 0, '0);
        step("mw_lateack", 0, 0, OP, 3'b000, 7'h00, 0, 1, S_RST, 0, '0);
        step("mw_no_wb",  0, 0, BR, 3'b000, 7'h00, 0, 0, S_BR_N, 1, D(3'b010, 4'b0000, 3'b000, 1, 1, 2'b10, 3'b000));

`ifdef CTRL_MC_TIMEOUT_EN
        step("to_req",   0, 0, LOAD, 3'b000, 7'h00, 0, 0, S_LD_W, 0, '0);
        for (int i = 0; i < 3; i++) step("to_wait", 0, 0, LOAD, 3'b000, 7'h00, 0, 0, S_LD_W, 0, '0);
        step("to_fire",  0, 0, LOAD, 3'b000, 7'h00, 0, 0, S_TO, 0, '0);
        step("to_err1",  0, 0, BR, 3'b000, 7'h00, 0, 0, S_BR_N | 11'd1, 0, '0);
        step("to_err2",  0, 0, BR, 3'b000, 7'h00, 0, 1, S_BR_N | 11'd1, 0, '0);
        step("to_rst",   0, 1, BR, 3'b000, 7'h00, 0, 0, S_RST, 0, '0);
        step("to_rst_nx", 0, 0, BR, 3'b000, 7'h00, 0, 0, S_RST, 0, '0);
        step("to_clear", 0, 0, BR, 3'b000, 7'h00, 0, 0, S_BR_N, 0, '0);
`else
        step("lw_req",   0, 0, LOAD, 3'b000, 7'h00, 0, 0, S_LD_W, 0, '0);
        for (int i = 0; i < 6; i++) step("lw_wait", 0, 0, LOAD, 3'b000, 7'h00, 0, 0, S_LD_W, 0, '0);
        step("lw_ack",   0, 0, LOAD, 3'b000, 7'h00, 0, 1, S_LD_W, 0, '0);
        step("lw_wb",    0, 0, BR, 3'b000, 7'h00, 0, 0, S_RUN, 0, '0);
        step("lw_after", 0, 0, BR, 3'b000, 7'h00, 0, 0, S_BR_N, 0, '0);
`endif

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
